// File: rtl/hex_scan_scheduler_pkg.sv
// rtl/hex_scan_scheduler_pkg.sv - shared types and constants for the hex scan scheduler
package hex_pkg;

  localparam int         SEG_W     = 7;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0]       nibble_t;
  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic {WR_IDLE, WR_COMMIT} wr_state_e;

endpackage

// File: rtl/hex_scan_scheduler_if.sv
// rtl/hex_scan_scheduler_if.sv - digit write port (valid/ready) between control logic and scheduler
interface hex_wr_if;
  import hex_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_digit;
  nibble_t    wr_value;

  modport master (output wr_valid, output wr_digit, output wr_value, input wr_ready);
  modport slave  (input wr_valid, input wr_digit, input wr_value, output wr_ready);

endinterface

// File: rtl/hex_scan_scheduler_decoder.sv
// rtl/hex_scan_scheduler_decoder.sv - active-low 7-segment decoder, segment order g..a
module hex_seg_decoder
  import hex_pkg::*;
(
  input  nibble_t nibble_i,
  output seg_t    seg_o
);

  always_comb begin
    seg_o = 7'b0001110;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/hex_scan_scheduler.sv
// rtl/hex_scan_scheduler.sv - one shared hex decoder refreshing NUM_DIGITS segment registers round-robin
module hex_scan_scheduler
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  hex_wr_if.slave                     wr,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  output logic [NUM_DIGITS*SEG_W-1:0] hex_out,
  output logic                        wr_err,
  output logic                        frame_done
);

  localparam int         PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int         DIV_W = $clog2(SCAN_DIV);
  localparam logic [3:0] ND4   = 4'(NUM_DIGITS);

  wr_state_e  state_q;
  logic       wr_ready_q;
  logic       wr_err_q;
  logic [2:0] pend_digit_q;
  nibble_t    pend_value_q;
  nibble_t    value_q [NUM_DIGITS];

  logic [DIV_W-1:0]            div_q, div_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic                        refresh;
  logic                        last_digit;
  logic                        frame_done_q;
  logic [NUM_DIGITS*SEG_W-1:0] hex_q;
  nibble_t                     dec_in;
  seg_t                        dec_out;

  // Out-of-range indices are latched like any other write so wr_err lines up with the commit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WR_IDLE;
      wr_ready_q   <= 1'b1;
      wr_err_q     <= 1'b0;
      pend_digit_q <= '0;
      pend_value_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) value_q[i] <= '0;
    end else begin
      case (state_q)
        WR_IDLE: begin
          if (wr.wr_valid) begin
            pend_digit_q <= wr.wr_digit;
            pend_value_q <= wr.wr_value;
            wr_ready_q   <= 1'b0;
            wr_err_q     <= ({1'b0, wr.wr_digit} >= ND4);
            state_q      <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pend_digit_q == 3'(i)) value_q[i] <= pend_value_q;
          end
          wr_ready_q <= 1'b1;
          wr_err_q   <= 1'b0;
          state_q    <= WR_IDLE;
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    refresh    = (div_q == DIV_W'(SCAN_DIV - 1));
    last_digit = (ptr_q == PTR_W'(NUM_DIGITS - 1));
    div_d      = refresh ? '0 : div_q + 1'b1;
    ptr_d      = ptr_q;
    if (refresh) ptr_d = last_digit ? '0 : ptr_q + 1'b1;
  end

  always_comb begin
    dec_in = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ptr_q == PTR_W'(i)) dec_in = value_q[i];
    end
  end

  hex_seg_decoder u_dec (
    .nibble_i (dec_in),
    .seg_o    (dec_out)
  );

  // Reads value_q before a same-edge commit lands, so a colliding write shows a slot later.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      ptr_q        <= '0;
      frame_done_q <= 1'b0;
      hex_q        <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      div_q        <= div_d;
      ptr_q        <= ptr_d;
      frame_done_q <= refresh && last_digit;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (refresh && ptr_q == PTR_W'(i))
          hex_q[i*SEG_W +: SEG_W] <= blank_mask[i] ? SEG_BLANK : dec_out;
      end
    end
  end

  assign wr.wr_ready = wr_ready_q;
  assign wr_err      = wr_err_q;
  assign frame_done  = frame_done_q;
  assign hex_out     = hex_q;

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// tb/tb_hex_scan_scheduler.sv - directed self-checking bench for hex_scan_scheduler
module tb_hex_scan_scheduler;

  localparam int N = 6;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  blank_mask = '0;
  logic [N*7-1:0] hex_out;
  logic          wr_err;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  hex_wr_if wr_if ();

  hex_scan_scheduler #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_if),
    .blank_mask (blank_mask),
    .hex_out    (hex_out),
    .wr_err     (wr_err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] slice(input int i);
    return hex_out[i*7 +: 7];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_digit = '0;
    wr_if.wr_value = '0;
    blank_mask = '0;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic do_write(input logic [2:0] d, input logic [3:0] v, input logic exp_err);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_digit = d;
    wr_if.wr_value = v;
    tick();
    wr_if.wr_valid = 1'b0;
    checks++;
    if (wr_if.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_ready got %b want 0", wr_if.wr_ready);
    end
    checks++;
    if (wr_err !== exp_err) begin
      errors++;
      $display("FAIL commit_err digit %0d got %b want %b", d, wr_err, exp_err);
    end
    tick();
    checks++;
    if (wr_if.wr_ready !== 1'b1 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL post_commit ready %b err %b want 1 0", wr_if.wr_ready, wr_err);
    end
  endtask

  task automatic test_reset();
    logic [N*7-1:0] exp;
    do_reset();
    checks++;
    if (hex_out !== {N{7'h7F}} || wr_if.wr_ready !== 1'b1 || wr_err !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state hex %h rdy %b err %b fd %b", hex_out, wr_if.wr_ready, wr_err, frame_done);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      for (int i = 0; i < N; i++) exp[i*7 +: 7] = (k >= D*(i+1)) ? 7'b1000000 : 7'h7F;
      checks++;
      if (hex_out !== exp) begin
        errors++;
        $display("FAIL idle_scan cycle %0d got %h want %h", k, hex_out, exp);
      end
      checks++;
      if (frame_done !== (k == 24)) begin
        errors++;
        $display("FAIL frame_done cycle %0d got %b want %b", k, frame_done, (k == 24));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_write(3'd0, 4'h1, 1'b0);
    do_write(3'd5, 4'hF, 1'b0);
    run_to(26);
    checks++;
    if (slice(0) !== 7'b1111001) begin
      errors++;
      $display("FAIL b2b_slice0 got %b want 1111001", slice(0));
    end
    checks++;
    if (slice(5) !== 7'b0001110) begin
      errors++;
      $display("FAIL b2b_slice5 got %b want 0001110", slice(5));
    end
    checks++;
    if (slice(3) !== 7'b1000000) begin
      errors++;
      $display("FAIL b2b_slice3 got %b want 1000000", slice(3));
    end
  endtask

  task automatic test_bad_digit();
    do_reset();
    run_to(24);
    do_write(3'd7, 4'h8, 1'b1);
    run_to(52);
    checks++;
    if (hex_out !== {N{7'b1000000}}) begin
      errors++;
      $display("FAIL bad_digit_hex got %h want %h", hex_out, {N{7'b1000000}});
    end
  endtask

  task automatic test_blank();
    do_reset();
    do_write(3'd2, 4'h3, 1'b0);
    run_to(12);
    checks++;
    if (slice(2) !== 7'b0110000) begin
      errors++;
      $display("FAIL blank_pre got %b want 0110000", slice(2));
    end
    blank_mask = 6'b000100;
    run_to(35);
    checks++;
    if (slice(2) !== 7'b0110000) begin
      errors++;
      $display("FAIL blank_before_slot got %b want 0110000", slice(2));
    end
    tick();
    checks++;
    if (slice(2) !== 7'h7F || slice(1) !== 7'b1000000) begin
      errors++;
      $display("FAIL blank_on s2 %b s1 %b want 1111111 1000000", slice(2), slice(1));
    end
    blank_mask = '0;
    run_to(59);
    checks++;
    if (slice(2) !== 7'h7F) begin
      errors++;
      $display("FAIL blank_hold got %b want 1111111", slice(2));
    end
    tick();
    checks++;
    if (slice(2) !== 7'b0110000) begin
      errors++;
      $display("FAIL blank_off got %b want 0110000", slice(2));
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    do_write(3'd1, 4'h2, 1'b0);
    run_to(8);
    checks++;
    if (slice(1) !== 7'b0100100) begin
      errors++;
      $display("FAIL same_init got %b want 0100100", slice(1));
    end
    run_to(30);
    do_write(3'd1, 4'hA, 1'b0);
    checks++;
    if (cyc != 32 || slice(1) !== 7'b0100100) begin
      errors++;
      $display("FAIL same_old cycle %0d got %b want 0100100", cyc, slice(1));
    end
    run_to(55);
    checks++;
    if (slice(1) !== 7'b0100100) begin
      errors++;
      $display("FAIL same_hold got %b want 0100100", slice(1));
    end
    tick();
    checks++;
    if (slice(1) !== 7'b0001000) begin
      errors++;
      $display("FAIL same_new got %b want 0001000", slice(1));
    end
  endtask

  task automatic test_reset_mid_write();
    int err_seen;
    err_seen = 0;
    do_reset();
    run_to(10);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_digit = 3'd3;
    wr_if.wr_value = 4'h9;
    tick();
    wr_if.wr_valid = 1'b0;
    if (wr_err !== 1'b0) err_seen++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    checks++;
    if (hex_out !== {N{7'h7F}} || wr_err !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state hex %h err %b rdy %b", hex_out, wr_err, wr_if.wr_ready);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (wr_err !== 1'b0) err_seen++;
    end
    checks++;
    if (slice(3) !== 7'b1000000) begin
      errors++;
      $display("FAIL midreset_digit3 got %b want 1000000", slice(3));
    end
    checks++;
    if (err_seen != 0) begin
      errors++;
      $display("FAIL midreset_err pulses %0d want 0", err_seen);
    end
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_digit = '0;
    wr_if.wr_value = '0;
    test_reset();
    test_back_to_back();
    test_bad_digit();
    test_blank();
    test_same_cycle();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
